// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the decode-side pipeline blocks.
//   - Major opcode constants recognised by the ID stage.
//   - ALU operation class encodings carried into EX.
//   - id_ex_ctrl_t: every control bit of the ID/EX register in one packed
//     struct, so inserting a bubble is a single '0 assignment.
package riscv_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int REG_AW_DEF = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'b00,  // address generation for loads/stores
        ALU_OP_BRANCH = 2'b01,  // branch compare
        ALU_OP_FUNCT  = 2'b10   // EX decodes funct bits
    } alu_op_e;

    typedef struct packed {
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    reg_write;
        logic    branch;
        alu_op_e alu_op;
    } id_ex_ctrl_t;

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// imm_gen: combinational immediate generator.
//   i_instr : 32-bit instruction word
//   o_imm   : XLEN-bit sign-extended immediate (I, S or B format by opcode;
//             zero for R-type and unrecognised opcodes)
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    // Bits that never contribute to any supported immediate format.
    logic w_unused;
    assign w_unused = &{1'b0, i_instr[19:12], 1'b0};

    always_comb begin
        o_imm = '0;
        case (i_instr[6:0])
            OP_IMM, OP_LOAD:
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
            OP_STORE:
                o_imm = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            // Branch offsets are byte offsets with an implicit zero LSB.
            OP_BRANCH:
                o_imm = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            default:
                o_imm = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: instruction decode plus the ID/EX pipeline register.
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   if_id_valid/instr/pc : instruction currently held in IF/ID
//   rs1_addr, rs2_addr   : register-file read addresses (combinational)
//   rs1_data, rs2_data   : register-file read data (combinational return)
//   wb_reg_write/rd/data : WB-stage write port, bypassed into ID
//   flush                : squash the instruction in ID (branch taken in EX)
//   stall_if             : hold PC and IF/ID for a load-use hazard
//   ex_*                 : registered ID/EX outputs consumed by EX
//
// Valid semantics: ex_valid marks a real instruction in EX. Every control
// bit is zero whenever ex_valid is zero (bubble, flush, invalid IF/ID), so
// downstream stages may use the control bits without re-qualifying them.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_id_valid,
    input  logic [31:0]       if_id_instr,
    input  logic [XLEN-1:0]   if_id_pc,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              stall_if,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_alu_src,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic              ex_branch,
    output logic [1:0]        ex_alu_op,
    output logic [3:0]        ex_funct
);

    logic [6:0]        w_opcode;
    logic [REG_AW-1:0] w_rd;
    logic [3:0]        w_funct;
    logic [XLEN-1:0]   w_imm;
    id_ex_ctrl_t       w_ctrl;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic              w_hazard;
    logic              w_bubble;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [3:0]        r_funct;
    id_ex_ctrl_t       r_ctrl;

    assign w_opcode = if_id_instr[6:0];
    assign rs1_addr = if_id_instr[19:15];
    assign rs2_addr = if_id_instr[24:20];
    assign w_rd     = if_id_instr[11:7];
    assign w_funct  = {if_id_instr[30], if_id_instr[14:12]};

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (if_id_instr),
        .o_imm   (w_imm)
    );

    // Main decode: control bits and which source registers are really read.
    always_comb begin
        w_ctrl    = '0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALU_OP_FUNCT;
                w_use_rs1        = 1'b1;
                w_use_rs2        = 1'b1;
            end
            OP_IMM: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_op    = ALU_OP_FUNCT;
                w_use_rs1        = 1'b1;
            end
            OP_LOAD: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.alu_op     = ALU_OP_ADD;
                w_use_rs1         = 1'b1;
            end
            OP_STORE: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_op    = ALU_OP_ADD;
                w_use_rs1        = 1'b1;
                w_use_rs2        = 1'b1;
            end
            OP_BRANCH: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.alu_op = ALU_OP_BRANCH;
                w_use_rs1     = 1'b1;
                w_use_rs2     = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    // Operand select. The register file commits on the same edge this stage
    // samples, so a same-cycle WB write must be forwarded here.
    always_comb begin
        w_rs1_val = rs1_data;
        if (rs1_addr == '0)
            w_rs1_val = '0;
        else if (wb_reg_write && (wb_rd == rs1_addr))
            w_rs1_val = wb_data;

        w_rs2_val = rs2_data;
        if (rs2_addr == '0)
            w_rs2_val = '0;
        else if (wb_reg_write && (wb_rd == rs2_addr))
            w_rs2_val = wb_data;
    end

    // Load-use: a load in EX whose result the ID instruction actually needs.
    assign w_hazard = r_valid && r_ctrl.mem_read && (r_rd != '0) && if_id_valid &&
                      ((w_use_rs1 && (r_rd == rs1_addr)) ||
                       (w_use_rs2 && (r_rd == rs2_addr)));

    // Flush outranks the hazard: the stalled instruction is being squashed.
    assign stall_if = w_hazard && !flush && !reset;

    // Reset, flush, hazard and an empty IF/ID all load an all-zero bubble.
    assign w_bubble = flush || w_hazard || !if_id_valid;

    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_funct    <= '0;
            r_ctrl     <= '0;
        end else begin
            r_valid    <= 1'b1;
            r_pc       <= if_id_pc;
            r_rs1_data <= w_rs1_val;
            r_rs2_data <= w_rs2_val;
            r_imm      <= w_imm;
            r_rs1      <= rs1_addr;
            r_rs2      <= rs2_addr;
            r_rd       <= w_rd;
            r_funct    <= w_funct;
            r_ctrl     <= w_ctrl;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_rs1_data   = r_rs1_data;
    assign ex_rs2_data   = r_rs2_data;
    assign ex_imm        = r_imm;
    assign ex_rs1        = r_rs1;
    assign ex_rs2        = r_rs2;
    assign ex_rd         = r_rd;
    assign ex_funct      = r_funct;
    assign ex_alu_src    = r_ctrl.alu_src;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_branch     = r_ctrl.branch;
    assign ex_alu_op     = r_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, immediates, bypass, load-use
// stall, flush priority and reset during a stall.
module tb_id_ex_stage;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    localparam logic [31:0] I_ADD3  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_LD5   = 32'hFF80B283; // ld   x5,-8(x1)
    localparam logic [31:0] I_ADD6  = 32'h00528333; // add  x6,x5,x5
    localparam logic [31:0] I_ADDI7 = 32'h00500393; // addi x7,x0,5
    localparam logic [31:0] I_BEQ   = 32'hFE208EE3; // beq  x1,x2,-4
    localparam logic [31:0] I_SW    = 32'h0020A623; // sw   x2,12(x1)
    localparam logic [31:0] I_LUI   = 32'h000012B7; // lui  x5,1 (not decoded)

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              if_id_valid;
    logic [31:0]       if_id_instr;
    logic [XLEN-1:0]   if_id_pc;
    logic [REG_AW-1:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0]   rs1_data, rs2_data;
    logic              wb_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic              flush;
    logic              stall_if;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic              ex_alu_src, ex_mem_read, ex_mem_write;
    logic              ex_mem_to_reg, ex_reg_write, ex_branch;
    logic [1:0]        ex_alu_op;
    logic [3:0]        ex_funct;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .flush         (flush),
        .stall_if      (stall_if),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_rs1_data   (ex_rs1_data),
        .ex_rs2_data   (ex_rs2_data),
        .ex_imm        (ex_imm),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_alu_src    (ex_alu_src),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_reg_write  (ex_reg_write),
        .ex_branch     (ex_branch),
        .ex_alu_op     (ex_alu_op),
        .ex_funct      (ex_funct)
    );

    // {alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, alu_op}
    logic [7:0] ctrl_obs;
    assign ctrl_obs = {ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                       ex_reg_write, ex_branch, ex_alu_op};

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] instr,
                         input logic [XLEN-1:0] pc);
        if_id_valid = valid;
        if_id_instr = instr;
        if_id_pc    = pc;
    endtask

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        wb_reg_write = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        rs1_data     = 64'd2;
        rs2_data     = 64'd3;
        drive(1'b1, I_LD5, 64'h40);
        tick();
        tick();
        // reset state (a load in ID must not stall while reset is high)
        check("rst_valid", {63'd0, ex_valid}, 64'd0);
        check("rst_ctrl", {56'd0, ctrl_obs}, 64'd0);
        check("rst_data", ex_pc | ex_rs1_data | ex_rs2_data | ex_imm, 64'd0);
        check("rst_idx", {49'd0, ex_rs1, ex_rs2, ex_rd}, 64'd0);
        check("rst_stall", {63'd0, stall_if}, 64'd0);
        reset = 1'b0;

        // add x3,x1,x2
        drive(1'b1, I_ADD3, 64'h10);
        #1;
        check("add_rs1_addr", {59'd0, rs1_addr}, 64'd1);
        check("add_rs2_addr", {59'd0, rs2_addr}, 64'd2);
        tick();
        check("add_valid", {63'd0, ex_valid}, 64'd1);
        check("add_rd", {59'd0, ex_rd}, 64'd3);
        check("add_rs1d", ex_rs1_data, 64'd2);
        check("add_rs2d", ex_rs2_data, 64'd3);
        check("add_ctrl", {56'd0, ctrl_obs}, 64'b0000_1010);
        check("add_imm", ex_imm, 64'd0);
        check("add_pc", ex_pc, 64'h10);

        // ld x5,-8(x1)
        drive(1'b1, I_LD5, 64'h14);
        rs1_data = 64'h100;
        tick();
        check("ld_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        check("ld_ctrl", {56'd0, ctrl_obs}, 64'b1101_1000);
        check("ld_rd", {59'd0, ex_rd}, 64'd5);
        check("ld_funct", {60'd0, ex_funct}, 64'hB);

        // add x6,x5,x5 right behind the load: one-cycle stall
        drive(1'b1, I_ADD6, 64'h18);
        rs1_data = 64'd11;
        rs2_data = 64'd11;
        #1;
        check("lu_stall", {63'd0, stall_if}, 64'd1);
        tick();
        check("lu_bubble_valid", {63'd0, ex_valid}, 64'd0);
        check("lu_bubble_ctrl", {56'd0, ctrl_obs}, 64'd0);
        check("lu_stall_drop", {63'd0, stall_if}, 64'd0);
        tick();
        check("lu_add_valid", {63'd0, ex_valid}, 64'd1);
        check("lu_add_rd", {59'd0, ex_rd}, 64'd6);
        check("lu_add_rs1", {59'd0, ex_rs1}, 64'd5);
        check("lu_add_rs2d", ex_rs2_data, 64'd11);

        // load followed by addi whose unused rs2 field matches: no stall
        drive(1'b1, I_LD5, 64'h1C);
        tick();
        drive(1'b1, I_ADDI7, 64'h20);
        rs1_data = 64'd99;
        #1;
        check("addi_no_stall", {63'd0, stall_if}, 64'd0);
        tick();
        check("addi_imm", ex_imm, 64'd5);
        check("addi_rs1_x0", ex_rs1_data, 64'd0);
        check("addi_ctrl", {56'd0, ctrl_obs}, 64'b1000_1010);

        // beq x1,x2,-4
        drive(1'b1, I_BEQ, 64'h24);
        rs1_data = 64'd1;
        rs2_data = 64'd2;
        tick();
        check("beq_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq_ctrl", {56'd0, ctrl_obs}, 64'b0000_0101);

        // next instruction squashed by flush
        drive(1'b1, I_SW, 64'h28);
        flush = 1'b1;
        tick();
        check("flush_valid", {63'd0, ex_valid}, 64'd0);
        check("flush_ctrl", {56'd0, ctrl_obs}, 64'd0);
        flush = 1'b0;

        // sw x2,12(x1)
        tick();
        check("sw_imm", ex_imm, 64'd12);
        check("sw_ctrl", {56'd0, ctrl_obs}, 64'b1010_0000);
        check("sw_rs2d", ex_rs2_data, 64'd2);

        // WB write-through bypass
        wb_reg_write = 1'b1;
        wb_rd        = 5'd1;
        wb_data      = 64'hDEAD;
        rs1_data     = 64'd7;
        rs2_data     = 64'd3;
        drive(1'b1, I_ADD3, 64'h2C);
        tick();
        check("byp_rs1d", ex_rs1_data, 64'hDEAD);
        check("byp_rs2d", ex_rs2_data, 64'd3);
        wb_rd = 5'd0;
        tick();
        check("byp_wbrd0", ex_rs1_data, 64'd7);
        drive(1'b1, I_ADDI7, 64'h30);
        tick();
        check("byp_x0", ex_rs1_data, 64'd0);
        wb_reg_write = 1'b0;

        // flush and hazard together
        drive(1'b1, I_LD5, 64'h34);
        tick();
        drive(1'b1, I_ADD6, 64'h38);
        flush = 1'b1;
        #1;
        check("fh_stall", {63'd0, stall_if}, 64'd0);
        tick();
        check("fh_bubble", {63'd0, ex_valid}, 64'd0);
        flush = 1'b0;
        tick();
        check("fh_after_rd", {59'd0, ex_rd}, 64'd6);

        // invalid IF/ID: never produces control
        drive(1'b0, I_LD5, 64'h3C);
        tick();
        check("inv_valid", {63'd0, ex_valid}, 64'd0);
        check("inv_ctrl", {56'd0, ctrl_obs}, 64'd0);

        // unrecognised opcode: valid but no control, zero immediate
        drive(1'b1, I_LUI, 64'h40);
        tick();
        check("unk_valid", {63'd0, ex_valid}, 64'd1);
        check("unk_ctrl", {56'd0, ctrl_obs}, 64'd0);
        check("unk_imm", ex_imm, 64'd0);

        // reset during a stall
        drive(1'b1, I_LD5, 64'h44);
        tick();
        drive(1'b1, I_ADD6, 64'h48);
        #1;
        check("rs_stall_pre", {63'd0, stall_if}, 64'd1);
        reset = 1'b1;
        #1;
        check("rs_stall_drop", {63'd0, stall_if}, 64'd0);
        tick();
        check("rs_valid", {63'd0, ex_valid}, 64'd0);
        check("rs_ctrl", {56'd0, ctrl_obs}, 64'd0);
        check("rs_data", ex_pc | ex_rs1_data | ex_rs2_data | ex_imm, 64'd0);
        check("rs_rd", {59'd0, ex_rd}, 64'd0);
        reset = 1'b0;

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
